// File: rtl/expr_eval_sched_if.sv
// Token stream handshake between the infix token front end and the
// operator-precedence scheduler.
interface expr_eval_sched_if;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_kind;
    logic [1:0] tok_op;
    logic       tok_last;

    modport master (output tok_valid, tok_kind, tok_op, tok_last, input tok_ready);
    modport slave  (input tok_valid, tok_kind, tok_op, tok_last, output tok_ready);
endinterface

// File: rtl/expr_eval_sched.sv
// Operator-precedence scheduler driving operand/operator stacks and the ALU.
// Optional macro EXPR_DIVZERO_CHK_EN: abort a reduction on ALU divide-by-zero.
module expr_eval_sched #(
    parameter int ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    expr_eval_sched_if.slave        tok,
    output logic                    opnd_push,
    output logic                    opnd_src,
    output logic                    opnd_pop,
    input  logic                    opnd_full,
    input  logic                    opnd_lt2,
    input  logic                    opnd_one,
    output logic                    op_push,
    output logic [2:0]              op_din,
    output logic                    op_pop,
    input  logic [2:0]              op_top,
    input  logic                    op_empty,
    input  logic                    op_full,
    output logic                    alu_ld_b,
    output logic                    alu_ld_a,
    output logic                    alu_go,
    output logic [1:0]              alu_op,
    input  logic                    alu_dz,
    output logic                    stk_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              err_code
);
    typedef enum logic [3:0] {
        S_IDLE, S_EVAL, S_RED_B, S_RED_A, S_RED_OP, S_RED_PUSH,
        S_PUSH_OP, S_POP_PAREN, S_FINISH, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] K_NUM = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_LP  = 2'b10;
    localparam logic [2:0] E_PAREN = 3'b001;
    localparam logic [2:0] E_CNT   = 3'b010;
    localparam logic [2:0] E_OVF   = 3'b011;
    localparam logic [2:0] E_DZ    = 3'b100;
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic [1:0] op_q, op_d;
    logic       last_q, last_d;
    logic       fin_q, fin_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] err_code_q, err_code_d;
    logic       accept;
    logic       start_red;

`ifndef EXPR_DIVZERO_CHK_EN
    logic unused_alu_dz;
    assign unused_alu_dz = alu_dz;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= 2'b00;
            op_q       <= 2'b00;
            last_q     <= 1'b0;
            fin_q      <= 1'b0;
            cnt_q      <= 3'd0;
            err_code_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            op_q       <= op_d;
            last_q     <= last_d;
            fin_q      <= fin_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign err_code = err_code_q;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        op_d          = op_q;
        last_d        = last_q;
        fin_d         = fin_q;
        cnt_d         = cnt_q;
        err_code_d    = err_code_q;
        tok.tok_ready = 1'b0;
        opnd_push     = 1'b0;
        opnd_src      = 1'b0;
        opnd_pop      = 1'b0;
        op_push       = 1'b0;
        op_din        = 3'b000;
        op_pop        = 1'b0;
        alu_ld_b      = 1'b0;
        alu_ld_a      = 1'b0;
        alu_go        = 1'b0;
        alu_op        = 2'b00;
        stk_clr       = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        start_red     = 1'b0;
        // Reset is folded in so strobes stay low while it is held.
        accept        = tok.tok_valid && !reset;

        unique case (state_q)
            S_IDLE: begin
                tok.tok_ready = 1'b1;
                if (accept) begin
                    if (tok.tok_kind == K_NUM) begin
                        if (opnd_full) begin
                            state_d    = S_ERR;
                            err_code_d = E_OVF;
                        end else begin
                            opnd_push = 1'b1;
                            if (tok.tok_last) state_d = S_FINISH;
                        end
                    end else begin
                        kind_d  = tok.tok_kind;
                        op_d    = tok.tok_op;
                        last_d  = tok.tok_last;
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                case (kind_q)
                    K_OP: begin
                        // Precedence is the high bit of the op code (* / over + -).
                        if (!op_empty && !op_top[2] && (op_top[1] >= op_q[1])) begin
                            start_red = 1'b1;
                        end else if (op_full) begin
                            state_d    = S_ERR;
                            err_code_d = E_OVF;
                        end else begin
                            state_d = S_PUSH_OP;
                        end
                    end
                    K_LP: begin
                        if (op_full) begin
                            state_d    = S_ERR;
                            err_code_d = E_OVF;
                        end else begin
                            state_d = S_PUSH_OP;
                        end
                    end
                    default: begin
                        if (op_empty) begin
                            state_d    = S_ERR;
                            err_code_d = E_PAREN;
                        end else if (op_top[2]) begin
                            state_d = S_POP_PAREN;
                        end else begin
                            start_red = 1'b1;
                        end
                    end
                endcase
            end
            S_RED_B: begin
                alu_op   = op_top[1:0];
                opnd_pop = 1'b1;
                alu_ld_b = 1'b1;
                state_d  = S_RED_A;
            end
            S_RED_A: begin
                alu_op   = op_top[1:0];
                opnd_pop = 1'b1;
                alu_ld_a = 1'b1;
                cnt_d    = 3'd0;
                state_d  = S_RED_OP;
            end
            S_RED_OP: begin
                alu_op = op_top[1:0];
                alu_go = (cnt_q == 3'd0);
                if (cnt_q == LAT_LAST) begin
`ifdef EXPR_DIVZERO_CHK_EN
                    if ((op_top[1:0] == 2'b11) && alu_dz) begin
                        state_d    = S_ERR;
                        err_code_d = E_DZ;
                    end else begin
                        state_d = S_RED_PUSH;
                    end
`else
                    state_d = S_RED_PUSH;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RED_PUSH: begin
                alu_op    = op_top[1:0];
                opnd_push = 1'b1;
                opnd_src  = 1'b1;
                op_pop    = 1'b1;
                state_d   = fin_q ? S_FINISH : S_EVAL;
            end
            S_PUSH_OP: begin
                op_push = 1'b1;
                op_din  = (kind_q == K_LP) ? 3'b100 : {1'b0, op_q};
                state_d = last_q ? S_FINISH : S_IDLE;
            end
            S_POP_PAREN: begin
                op_pop  = 1'b1;
                state_d = last_q ? S_FINISH : S_IDLE;
            end
            S_FINISH: begin
                if (op_empty) begin
                    if (opnd_one) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = E_CNT;
                    end
                end else if (op_top[2]) begin
                    state_d    = S_ERR;
                    err_code_d = E_PAREN;
                end else begin
                    start_red = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                stk_clr = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err           = 1'b1;
                tok.tok_ready = 1'b1;
                if (accept && tok.tok_last) begin
                    stk_clr    = 1'b1;
                    err_code_d = 3'b000;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every reduction needs two operands; the return target is remembered in fin.
        if (start_red) begin
            fin_d = (state_q == S_FINISH);
            if (opnd_lt2) begin
                state_d    = S_ERR;
                err_code_d = E_CNT;
            end else begin
                state_d = S_RED_B;
            end
        end
    end
endmodule
